// File: rtl/l1d_refill_ctrl_if.sv
// Bundle of handshake and data signals between the L1D refill controller
// and its surroundings: the miss FIFO, the memory port and the cache data array.
// The master modport is the controller's view of the bundle.
// The slave modport is the environment's view of the same signals.
interface l1d_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = 4
);
  // miss FIFO side
  logic                        req_empty;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic                        req_rd_ena;
  // memory request channel
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic [ADDR_WIDTH-1:0]       mem_req_addr;
  // memory response channel
  logic                        mem_rsp_valid;
  logic [BEAT_WIDTH-1:0]       mem_rsp_data;
  logic                        mem_rsp_last;
  // refill channel towards the data array
  logic                        refill_valid;
  logic                        refill_ready;
  logic [ADDR_WIDTH-1:0]       refill_addr;
  logic [BEAT_WIDTH*BEATS-1:0] refill_data;
  // status
  logic                        busy;
  logic                        err;

  modport master (
    input  req_empty, req_addr, mem_req_ready,
           mem_rsp_valid, mem_rsp_data, mem_rsp_last, refill_ready,
    output req_rd_ena, mem_req_valid, mem_req_addr,
           refill_valid, refill_addr, refill_data, busy, err
  );

  modport slave (
    output req_empty, req_addr, mem_req_ready,
           mem_rsp_valid, mem_rsp_data, mem_rsp_last, refill_ready,
    input  req_rd_ena, mem_req_valid, mem_req_addr,
           refill_valid, refill_addr, refill_data, busy, err
  );
endinterface

// File: rtl/l1d_refill_ctrl.sv
// L1D miss-refill controller.
// Pops one line address from the miss FIFO and issues it to memory.
// Gathers BEATS response beats into a line, then hands the line to the cache.
// Only one miss is in flight at a time; response beats that disagree with the
// expected framing raise a one-cycle err pulse.
module l1d_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,   // synchronous, active-high
  l1d_refill_ctrl_if.master   bus
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RSP    = 2'd2,
    ST_REFILL = 2'd3
  } state_t;

  state_t                      state_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [BEAT_WIDTH*BEATS-1:0] line_q;
  logic [CW-1:0]               beat_cnt_q;
  logic                        err_q;
  logic                        mem_req_valid_q;
  logic                        refill_valid_q;
  logic                        busy_q;

  // Main FSM: sequencing, address/line capture, beat counting and error flagging.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      line_q          <= '0;
      beat_cnt_q      <= '0;
      err_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      refill_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A beat with no outstanding miss is dropped and reported.
          if (bus.mem_rsp_valid) begin
            err_q <= 1'b1;
          end
          if (!bus.req_empty) begin
            addr_q          <= bus.req_addr;
            state_q         <= ST_REQ;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.mem_rsp_valid) begin
            err_q <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            beat_cnt_q      <= '0;
            state_q         <= ST_RSP;
            mem_req_valid_q <= 1'b0;
          end
        end
        ST_RSP: begin
          if (bus.mem_rsp_valid) begin
            line_q[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rsp_data;
            beat_cnt_q <= beat_cnt_q + CNT_ONE;
            // The beat count alone decides completion; last is only checked.
            if (bus.mem_rsp_last != (beat_cnt_q == LAST_BEAT)) begin
              err_q <= 1'b1;
            end
            if (beat_cnt_q == LAST_BEAT) begin
              state_q        <= ST_REFILL;
              refill_valid_q <= 1'b1;
            end
          end
        end
        ST_REFILL: begin
          if (bus.mem_rsp_valid) begin
            err_q <= 1'b1;
          end
          // Returning to IDLE first means the next pop is never in this cycle.
          if (bus.refill_ready) begin
            state_q        <= ST_IDLE;
            refill_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          mem_req_valid_q <= 1'b0;
          refill_valid_q  <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  // The pop is the only combinational output; it must stay low while reset is held.
  assign bus.req_rd_ena    = (state_q == ST_IDLE) && !bus.req_empty && !rst_n;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.refill_valid  = refill_valid_q;
  assign bus.refill_addr   = addr_q;
  assign bus.refill_data   = line_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// Self-checking bench for l1d_refill_ctrl: directed scenarios plus randomized
// misses checked against a line/err model built from the beat lists.
module tb_l1d_refill_ctrl;

  localparam int AW = 32;
  localparam int BW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;

  l1d_refill_ctrl_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) bus ();

  l1d_refill_ctrl #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int err_pulses = 0;
  int last_pop_cyc = 0;
  logic [BW-1:0]    beat_v [NB];
  logic             last_v [NB];
  logic [NB*BW-1:0] model_line = '0;

  // Cycle counter and err pulse counter, sampled on the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.err === 1'b1) err_pulses <= err_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_empty     = 1'b1;
    bus.req_addr      = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_last  = 1'b0;
    bus.refill_ready  = 1'b0;
  endtask

  // One complete miss with optional stalls; expectations from beat_v/last_v.
  task automatic run_miss(input logic [AW-1:0] addr, input int req_stall,
                          input int refill_stall, input int max_gap, input bit next_pending);
    logic [NB*BW-1:0] exp_line;
    int exp_err;
    int e0;
    int gaps;
    exp_line = '0;
    exp_err  = 0;
    for (int i = 0; i < NB; i++) begin
      exp_line[i*BW +: BW] = beat_v[i];
      if (last_v[i] != (i == NB - 1)) exp_err++;
    end
    e0 = err_pulses;
    bus.req_empty = 1'b0; bus.req_addr = addr; bus.mem_rsp_valid = 1'b0;
    bus.refill_ready = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.req_rd_ena !== 1'b1) $display("FAIL pop: got %b want 1", bus.req_rd_ena); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else pass_cnt++;
    last_pop_cyc = cyc;
    tick();
    bus.req_empty = !next_pending;
    bus.req_addr  = ~addr;
    for (int s = 0; s < req_stall; s++) begin
      bus.mem_req_ready = 1'b0;
      @(negedge clk);
      total_cnt++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== addr || bus.req_rd_ena !== 1'b0 || bus.busy !== 1'b1)
        $display("FAIL req_stall: valid=%b addr=%h pop=%b busy=%b want 1 %h 0 1", bus.mem_req_valid, bus.mem_req_addr, bus.req_rd_ena, bus.busy, addr);
      else pass_cnt++;
      tick();
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== addr)
      $display("FAIL req: valid=%b addr=%h want 1 %h", bus.mem_req_valid, bus.mem_req_addr, addr);
    else pass_cnt++;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      gaps = $urandom_range(max_gap, 0);
      for (int g = 0; g < gaps; g++) begin
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.refill_valid !== 1'b0 || bus.busy !== 1'b1)
          $display("FAIL rsp_gap: refill_valid=%b busy=%b want 0 1", bus.refill_valid, bus.busy);
        else pass_cnt++;
        tick();
      end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = beat_v[i]; bus.mem_rsp_last = last_v[i];
      @(negedge clk);
      total_cnt++; if (bus.mem_req_valid !== 1'b0 || bus.refill_valid !== 1'b0)
        $display("FAIL rsp: mem_req_valid=%b refill_valid=%b want 0 0", bus.mem_req_valid, bus.refill_valid);
      else pass_cnt++;
      tick();
    end
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_last = 1'b0;
    for (int s = 0; s < refill_stall; s++) begin
      bus.refill_ready = 1'b0;
      @(negedge clk);
      total_cnt++; if (bus.refill_valid !== 1'b1 || bus.refill_data !== exp_line || bus.refill_addr !== addr || bus.req_rd_ena !== 1'b0)
        $display("FAIL refill_stall: valid=%b data=%h addr=%h pop=%b want 1 %h %h 0", bus.refill_valid, bus.refill_data, bus.refill_addr, bus.req_rd_ena, exp_line, addr);
      else pass_cnt++;
      tick();
    end
    bus.refill_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.refill_valid !== 1'b1 || bus.refill_data !== exp_line || bus.refill_addr !== addr)
      $display("FAIL refill: valid=%b data=%h addr=%h want 1 %h %h", bus.refill_valid, bus.refill_data, bus.refill_addr, exp_line, addr);
    else pass_cnt++;
    tick();
    bus.refill_ready = 1'b0;
    if (!next_pending) bus.req_empty = 1'b1;
    model_line = exp_line;
    total_cnt++; if (err_pulses - e0 !== exp_err)
      $display("FAIL err_count: got %0d want %0d", err_pulses - e0, exp_err);
    else pass_cnt++;
  endtask

  task automatic set_clean_beats();
    for (int i = 0; i < NB; i++) begin
      beat_v[i] = $urandom;
      last_v[i] = (i == NB - 1);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    bus.req_empty = 1'b0;
    bus.req_addr = 32'h0000_DEAD;
    tick();
    tick();
    @(negedge clk);
    total_cnt++; if (bus.req_rd_ena !== 1'b0) $display("FAIL reset_pop: got %b want 0", bus.req_rd_ena); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.refill_valid !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b mreq=%b rfv=%b err=%b want 0 0 0 0", bus.busy, bus.mem_req_valid, bus.refill_valid, bus.err);
    else pass_cnt++;
    total_cnt++; if (bus.refill_data !== '0 || bus.refill_addr !== '0)
      $display("FAIL reset_data: data=%h addr=%h want 0 0", bus.refill_data, bus.refill_addr);
    else pass_cnt++;
    tick();
    rst_n = 1'b0;
    bus.req_empty = 1'b1;
    model_line = '0;
  endtask

  task automatic test_basic();
    beat_v[0] = 32'hA; beat_v[1] = 32'hB; beat_v[2] = 32'hC; beat_v[3] = 32'hD;
    last_v[0] = 1'b0; last_v[1] = 1'b0; last_v[2] = 1'b0; last_v[3] = 1'b1;
    run_miss(32'h0000_1000, 0, 0, 0, 1'b0);
    total_cnt++; if (model_line !== 128'h0000000D_0000000C_0000000B_0000000A)
      $display("FAIL basic_line: got %h", model_line);
    else pass_cnt++;
  endtask

  task automatic test_req_stall();
    set_clean_beats();
    run_miss(32'h0000_2040, 5, 0, 0, 1'b0);
  endtask

  task automatic test_refill_stall();
    set_clean_beats();
    run_miss(32'h0000_3080, 0, 4, 0, 1'b1);
    set_clean_beats();
    run_miss(32'h0000_30C0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first_pop;
    set_clean_beats();
    run_miss(32'h0000_4000, 0, 0, 0, 1'b1);
    first_pop = last_pop_cyc;
    set_clean_beats();
    run_miss(32'h0000_4040, 0, 0, 0, 1'b0);
    total_cnt++; if (last_pop_cyc - first_pop !== NB + 3)
      $display("FAIL b2b_period: got %0d want %0d", last_pop_cyc - first_pop, NB + 3);
    else pass_cnt++;
  endtask

  task automatic test_last_err();
    logic [NB*BW-1:0] exp_line;
    exp_line = '0;
    bus.req_empty = 1'b0; bus.req_addr = 32'h0000_5000;
    @(negedge clk);
    tick();
    bus.req_empty = 1'b1; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      beat_v[i] = $urandom;
      exp_line[i*BW +: BW] = beat_v[i];
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = beat_v[i]; bus.mem_rsp_last = (i == 1);
      @(negedge clk);
      total_cnt++; if (bus.err !== ((i == 2) ? 1'b1 : 1'b0))
        $display("FAIL last_err_beat%0d: got %b want %b", i, bus.err, (i == 2));
      else pass_cnt++;
      tick();
    end
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_last = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.err !== 1'b1 || bus.refill_valid !== 1'b1)
      $display("FAIL missing_last_err: err=%b refill_valid=%b want 1 1", bus.err, bus.refill_valid);
    else pass_cnt++;
    tick();
    bus.refill_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.err !== 1'b0 || bus.refill_data !== exp_line)
      $display("FAIL last_err_line: err=%b data=%h want 0 %h", bus.err, bus.refill_data, exp_line);
    else pass_cnt++;
    tick();
    bus.refill_ready = 1'b0;
    model_line = exp_line;
  endtask

  task automatic test_stray();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD0_BAD0; bus.mem_rsp_last = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_last = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.err !== 1'b1 || bus.refill_data !== model_line || bus.busy !== 1'b0)
      $display("FAIL stray: err=%b data=%h busy=%b want 1 %h 0", bus.err, bus.refill_data, bus.busy, model_line);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL stray_pulse_len: got %b want 0", bus.err); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req_empty = 1'b0; bus.req_addr = 32'h0000_6000;
    @(negedge clk);
    tick();
    bus.req_empty = 1'b1; bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom; bus.mem_rsp_last = 1'b0;
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    model_line = '0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.refill_data !== '0 || bus.mem_req_valid !== 1'b0 || bus.refill_valid !== 1'b0)
      $display("FAIL reset_mid: busy=%b data=%h mreq=%b rfv=%b want 0 0 0 0", bus.busy, bus.refill_data, bus.mem_req_valid, bus.refill_valid);
    else pass_cnt++;
    // a late beat from the abandoned miss
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom; bus.mem_rsp_last = 1'b0;
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.err !== 1'b1 || bus.refill_data !== '0)
      $display("FAIL late_beat: err=%b data=%h want 1 0", bus.err, bus.refill_data);
    else pass_cnt++;
    tick();
    set_clean_beats();
    run_miss(32'h0000_6040, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NB; i++) begin
        beat_v[i] = $urandom;
        last_v[i] = ($urandom_range(3, 0) == 0) ? 1'($urandom_range(1, 0)) : 1'(i == NB - 1);
      end
      run_miss($urandom, $urandom_range(3, 0), $urandom_range(3, 0), 2, 1'($urandom_range(1, 0)));
    end
    bus.req_empty = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_refill_stall();
    test_back_to_back();
    test_last_err();
    test_stray();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/l1d_refill_ctrl.md
# l1d_refill_ctrl

Miss-refill controller that sits directly downstream of the L1D miss-request FIFO. It pops one line address at a time from the FIFO and issues it to the memory side with a valid/ready handshake. It then collects `BEATS` response beats into a full line and presents the assembled line to the cache data array with a second valid/ready handshake. Only one miss is outstanding at a time; the FIFO absorbs further misses.

## Interface
- `ADDR_WIDTH`, default 32: line address width.
- `BEAT_WIDTH`, default 32: memory response beat width.
- `BEATS`, default 4: beats per line; power of two, ≥2. Beat counter width is `$clog2(BEATS)`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; **synchronous, active-high** (asserted = 1, sampled on `clk`).
- `req_empty`  in  1  miss FIFO empty flag.
- `req_addr`  in  ADDR_WIDTH  miss FIFO head (show-ahead read data).
- `req_rd_ena`  out  1  miss FIFO pop; head is consumed at the same edge.
- `mem_req_valid`  out  1  memory read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  ADDR_WIDTH  request line address.
- `mem_rsp_valid`  in  1  response beat valid; no backpressure.
- `mem_rsp_data`  in  BEAT_WIDTH  response beat.
- `mem_rsp_last`  in  1  final beat marker from memory.
- `refill_valid`  out  1  assembled line valid.
- `refill_ready`  in  1  cache accepts line.
- `refill_addr`  out  ADDR_WIDTH  line address of refill.
- `refill_data`  out  BEAT_WIDTH*BEATS  assembled line; beat 0 in bits [BEAT_WIDTH-1:0].
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
FSM states: IDLE, REQ, RSP, REFILL.
- IDLE:
  - `req_rd_ena = !req_empty` (combinational, IDLE only).
  - When `!req_empty`: latch `req_addr` into the address register and go to REQ.
- REQ:
  - `mem_req_valid = 1`; `mem_req_addr` comes from the address register and stays stable while it waits.
  - On `mem_req_ready`: clear the beat counter and go to RSP.
- RSP:
  - On each `mem_rsp_valid`, write `mem_rsp_data` into slot `beat_cnt` of the line register and increment `beat_cnt`.
  - On the beat where `beat_cnt == BEATS-1`, go to REFILL.
  - Completion is decided by the beat count only; `mem_rsp_last` is checked, never obeyed.
- REFILL:
  - `refill_valid = 1`; `refill_addr` and `refill_data` are held stable.
  - On `refill_ready`, go to IDLE. There is no pop in the same cycle; the next pop is in IDLE at the earliest.

Error detection: `err` is registered and asserted for exactly one cycle after either of these:
- `mem_rsp_valid` in RSP with `mem_rsp_last != (beat_cnt == BEATS-1)`;
- `mem_rsp_valid` in IDLE, REQ or REFILL. Such a beat is dropped; line register and counter are unchanged.

Arithmetic:
- `beat_cnt` wraps naturally from BEATS-1 to 0; it is only meaningful in RSP.
- The slot write uses an indexed part-select `beat_cnt*BEAT_WIDTH +: BEAT_WIDTH`.

Reset (`rst_n = 1` at a rising edge) has priority over everything, mid-transaction included:
- state → IDLE; address register, line register and `beat_cnt` → 0; `err` → 0.
- Combinational outputs follow: `req_rd_ena` = 0 while reset is held, `mem_req_valid` = 0, `refill_valid` = 0, `busy` = 0.
- An in-flight miss is abandoned. Any late beats after reset are flagged through `err`.

## Timing
- Pop to request: `req_rd_ena` at cycle T, `mem_req_valid` from T+1.
- Request to response: RSP is entered the cycle after the `mem_req_valid && mem_req_ready` handshake.
- Last beat to refill: last beat sampled at edge E, `refill_valid` high in the cycle after E.
- Minimum cycles per miss, with ready always high and beats back-to-back: 1 (IDLE) + 1 (REQ) + BEATS (RSP) + 1 (REFILL) = BEATS+3.
- Sustained throughput is therefore one line every BEATS+3 cycles.
- `err` appears one cycle after the offending beat.
- Valid/ready rules: once `mem_req_valid` or `refill_valid` is raised, it stays high with payload stable until the handshake. Neither valid depends combinationally on its ready.

## Test plan
1. Reset, then FIFO holds 0x1000 and all readies are 1; beats 0xA,0xB,0xC,0xD with `last` on 0xD -> `req_rd_ena` for 1 cycle, `mem_req_addr` = 0x1000, `refill_data` = 0x0000000D_0000000C_0000000B_0000000A after 7 cycles, `err` = 0.
2. `mem_req_ready` held 0 for 5 cycles -> `mem_req_valid` and `mem_req_addr` stable all 5 cycles, no pop, `busy` = 1; proceeds when ready rises.
3. `refill_ready` held 0 for 4 cycles with FIFO non-empty -> `refill_valid`/data stable, `req_rd_ena` = 0 throughout; pop occurs the cycle after the refill handshake.
4. `mem_rsp_last` asserted on beat 1 (of 4) -> `err` pulses 1 cycle later, still collects 4 beats; second `err` pulse for missing `last` on beat 3.
5. Stray `mem_rsp_valid` in IDLE -> `err` = 1 next cycle, `refill_data` unchanged.
6. Reset asserted in RSP after 2 beats -> next cycle `busy` = 0, `refill_data` = 0, state IDLE; a fresh miss then completes normally.
